// File: rtl/uart_cmd_wrapper.sv
// Robot-side command receiver: 8N1 UART, two-byte command assembly with inter-byte
// timeout, cmd_rdy/clr_cmd_rdy handshake and a pass-through response transmitter.
module uart_cmd_wrapper #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned BAUD_CYCLES    = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int unsigned BAUD_W  = (BAUD_CYCLES < 2) ? 1 : $clog2(BAUD_CYCLES);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CYCLES - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_CYCLES / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TO_LAST);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  // ---------------- UART receiver ----------------
  logic              rx_s1_q, rx_s2_q;
  logic              rx_busy_q;
  logic [BAUD_W-1:0] rx_baud_q;
  logic [3:0]        rx_bits_q;
  logic [7:0]        rx_shift_q;
  logic              rx_rdy_q;
  logic              clr_rx_rdy_c;

  // Two-flop synchronizer; idle-high reset avoids a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Samples mid-bit: start bit re-checked, 8 data bits LSB first, stop bit qualifies rx_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bits_q  <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      if (clr_rx_rdy_c) rx_rdy_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_baud_q <= BAUD_HALF;
          rx_bits_q <= '0;
        end
      end else if (rx_baud_q == '0) begin
        rx_baud_q <= BAUD_LAST;
        rx_bits_q <= rx_bits_q + 4'd1;
        if (rx_bits_q == 4'd0) begin
          if (rx_s2_q) rx_busy_q <= 1'b0;
        end else if (rx_bits_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          rx_rdy_q  <= rx_s2_q;
        end else begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
        end
      end else begin
        rx_baud_q <= rx_baud_q - BAUD_W'(1);
      end
    end
  end

  // The FSM accepts a byte in every state, so the clear is the ready itself.
  assign clr_rx_rdy_c = rx_rdy_q;

  // ---------------- UART transmitter ----------------
  logic              tx_busy_q;
  logic [BAUD_W-1:0] tx_baud_q;
  logic [3:0]        tx_bits_q;
  logic [9:0]        tx_shift_q;
  logic              tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bits_q  <= '0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (trmt) begin
          tx_shift_q <= {1'b1, resp, 1'b0};
          tx_busy_q  <= 1'b1;
          tx_baud_q  <= BAUD_LAST;
          tx_bits_q  <= '0;
        end
      end else if (tx_baud_q == '0) begin
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        tx_baud_q  <= BAUD_LAST;
        if (tx_bits_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
        end else begin
          tx_bits_q <= tx_bits_q + 4'd1;
        end
      end else begin
        tx_baud_q <= tx_baud_q - BAUD_W'(1);
      end
    end
  end

  assign TX      = tx_shift_q[0];
  assign tx_done = tx_done_q;

  // ---------------- Command assembly FSM ----------------
  state_t           state_q;
  logic [7:0]       high_q;
  logic [15:0]      cmd_q;
  logic             cmd_rdy_q;
  logic             frame_err_q;
  logic [CNT_W-1:0] to_cnt_q;

  // A completing frame overrides a same-cycle clr_cmd_rdy because it is assigned last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      high_q      <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      frame_err_q <= 1'b0;
      if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_rdy_q) begin
            high_q    <= rx_shift_q;
            cmd_rdy_q <= 1'b0;
            to_cnt_q  <= '0;
            state_q   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (rx_rdy_q) begin
            cmd_q     <= {high_q, rx_shift_q};
            cmd_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else if (TO_EN && (to_cnt_q == CNT_LAST)) begin
            high_q      <= '0;
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else if (to_cnt_q != CNT_MAX) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: table of two-byte frames checked through a scoreboard
// popped on each cmd_rdy rise, plus timeout, mid-frame reset and full-duplex sequences.
module tb_uart_cmd_wrapper;

  localparam int unsigned BAUD = 16;
  localparam int unsigned TOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;
  logic [7:0]  resp = 8'h00;
  logic        trmt = 1'b0;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.TIMEOUT_CYCLES(TOUT), .BAUD_CYCLES(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err), .resp(resp), .trmt(trmt),
    .tx_done(tx_done)
  );

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    bit          hold_clr;
    bit          clr_after;
    logic [15:0] exp_cmd;
  } vec_t;

  int          n_vec = 0;
  int          n_fail = 0;
  int          fe_cnt = 0;
  int          txd_cnt = 0;
  logic        rdy_prev = 1'b0;
  logic [15:0] sb[$];
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      tick(BAUD);
    end
    RX = 1'b1;
    tick(BAUD);
  endtask

  // Every accepted frame drops cmd_rdy at its high byte, so each frame yields one rise.
  task automatic monitor();
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (tx_done) txd_cnt++;
      if (cmd_rdy && !rdy_prev) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_cmd_rdy: got cmd %0h, expected no frame", cmd);
        end else begin
          exp = sb.pop_front();
          check("cmd_at_rdy", 32'(cmd), 32'(exp));
        end
      end
      rdy_prev = cmd_rdy;
    end
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  task automatic apply_vec(input vec_t v);
    clr_cmd_rdy = v.hold_clr;
    sb.push_back(v.exp_cmd);
    send_byte(v.hi);
    send_byte(v.lo);
    wait_sb();
    tick(2);
    check("cmd", 32'(cmd), 32'(v.exp_cmd));
    check("cmd_rdy", 32'(cmd_rdy), v.hold_clr ? 32'(0) : 32'(1));
    clr_cmd_rdy = 1'b0;
    if (v.clr_after) begin
      clr_cmd_rdy = 1'b1;
      tick(1);
      clr_cmd_rdy = 1'b0;
      check("cmd_rdy_after_clr", 32'(cmd_rdy), 32'(0));
      check("cmd_held_after_clr", 32'(cmd), 32'(v.exp_cmd));
    end
  endtask

  task automatic tx_decode();
    logic [7:0] d;
    logic       st, sp;
    int         i;
    d = '0;
    for (i = 0; i < 400 && TX !== 1'b0; i++) @(negedge clk);
    check("tx_start_seen", 32'(TX), 32'(0));
    repeat (BAUD / 2) @(negedge clk);
    st = TX;
    for (int b = 0; b < 8; b++) begin
      repeat (BAUD) @(negedge clk);
      d[b] = TX;
    end
    repeat (BAUD) @(negedge clk);
    sp = TX;
    check("tx_start_bit", 32'(st), 32'(0));
    check("tx_data", 32'(d), 32'(8'hA5));
    check("tx_stop_bit", 32'(sp), 32'(1));
  endtask

  initial begin
    int   fe0, txd0;
    vec_t v;

    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 16'hA53C};
    vecs[1] = '{8'h12, 8'h34, 1'b0, 1'b0, 16'h1234};
    vecs[2] = '{8'h11, 8'h11, 1'b0, 1'b0, 16'h1111};
    vecs[3] = '{8'h22, 8'h22, 1'b0, 1'b0, 16'h2222};
    vecs[4] = '{8'h5A, 8'hC3, 1'b1, 1'b0, 16'h5AC3};

    fork
      monitor();
    join_none

    tick(3);
    check("reset_cmd", 32'(cmd), 32'(0));
    check("reset_cmd_rdy", 32'(cmd_rdy), 32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_tx", 32'(TX), 32'(1));
    check("reset_tx_done", 32'(tx_done), 32'(0));
    rst_n = 1'b1;
    tick(5);

    foreach (vecs[i]) apply_vec(vecs[i]);
    check("no_frame_err_yet", 32'(fe_cnt), 32'(0));

    // Lone high byte must time out and be discarded.
    fe0 = fe_cnt;
    send_byte(8'h7F);
    tick(1200);
    check("timeout_frame_err_pulse", 32'(fe_cnt - fe0), 32'(1));
    check("timeout_cmd_held", 32'(cmd), 32'(16'h5AC3));
    check("timeout_cmd_rdy", 32'(cmd_rdy), 32'(0));
    v = '{8'h00, 8'h01, 1'b0, 1'b0, 16'h0001};
    apply_vec(v);

    // Reset with a high byte pending: the byte must be lost.
    send_byte(8'hC3);
    tick(10);
    rst_n = 1'b0;
    #2;
    check("midreset_cmd", 32'(cmd), 32'(0));
    check("midreset_cmd_rdy", 32'(cmd_rdy), 32'(0));
    check("midreset_tx", 32'(TX), 32'(1));
    tick(2);
    rst_n = 1'b1;
    tick(3);
    v = '{8'h55, 8'hAA, 1'b0, 1'b0, 16'h55AA};
    apply_vec(v);

    // Full duplex: transmit a response while a command arrives.
    txd0 = txd_cnt;
    resp = 8'hA5;
    trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
    v = '{8'hBE, 8'hEF, 1'b0, 1'b0, 16'hBEEF};
    fork
      apply_vec(v);
      tx_decode();
    join
    tick(4 * BAUD);
    check("tx_done_pulse", 32'(txd_cnt - txd0), 32'(1));
    check("tx_idle_high", 32'(TX), 32'(1));
    check("final_frame_err_count", 32'(fe_cnt - fe0), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
